uart_tx_feeder: RTL and testbench

Transmit-side buffer and sequencer that sits directly upstream of the Duplex UART.
- Accepts bytes from the system side over a valid/ready handshake and stores them in a FIFO.
- Pops one byte at a time and drives the Duplex send/data_in inputs.
- Uses the Duplex tx_active_flag/tx_done_flag to pace frames back-to-back without dropping or duplicating bytes.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tx_feeder_if.sv | 12 +
 rtl/uart_sync_fifo.sv | 62 ++++++
 rtl/uart_tx_feeder.sv | 96 +++++++++
 tb/tb_uart_tx_feeder.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: data width, feeder FSM states,
// and the parity/baud encodings that the Duplex UART consumes.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DRAIN  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_ODD  = 2'b01,
    PAR_EVEN = 2'b10
  } parity_e;

  typedef enum logic [1:0] {
    BAUD_9600  = 2'b10,
    BAUD_19200 = 2'b11
  } baud_e;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Byte write handshake between the system side (master) and the transmit feeder (slave).
interface uart_tx_feeder_if;
  import uart_pkg::*;

  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;

  modport master (output wr_data, output wr_valid, input wr_ready);
  modport slave  (input wr_data, input wr_valid, output wr_ready);

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count; flush empties it and swallows any same-cycle push/pop.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full
);

  localparam logic [ADDR_W:0] DEPTH_CNT = DEPTH[ADDR_W:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;

  // A full FIFO refuses a push even when a pop lands on the same edge.
  assign do_push = push && !full  && !flush;
  assign do_pop  = pop  && !empty && !flush;

  // NOTE: storage has no reset; a slot is only read after it was written, and a reset-free array maps onto RAM.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == DEPTH_CNT);

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers system bytes and hands them one at a time to the Duplex UART, pacing
// on its active/done flags; a missing acknowledge drops the byte and raises a sticky timeout.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic              clock,
  input  logic              reset_n,
  uart_tx_feeder_if.slave   wr,
  input  logic              flush,
  input  logic              tx_active_flag,
  input  logic              tx_done_flag,
  output logic              send,
  output logic [DATA_W-1:0] tx_data,
  output logic [ADDR_W:0]   fill_level,
  output logic              empty,
  output logic              full,
  output logic              busy,
  output logic              tx_timeout
);

  localparam int              CNT_W   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_TIMEOUT - 1);

  tx_state_e         state_q, state_d;
  logic              pop;
  logic              expire;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rdata;

  assign wr.wr_ready = !full;

  uart_sync_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (wr.wr_valid),
    .pop     (pop),
    .flush   (flush),
    .wdata   (wr.wr_data),
    .rdata   (rdata),
    .count   (fill_level),
    .empty   (empty),
    .full    (full)
  );

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    expire  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // flush wins over a pending pop
        if (!empty && !flush) begin
          pop     = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // active beats an expiry on the same cycle; a stale done is ignored here
        if (tx_active_flag) begin
          state_d = ST_ACTIVE;
        end else if (cnt_q == CNT_MAX) begin
          expire  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: if (tx_done_flag) state_d = ST_DRAIN;
      ST_DRAIN:  if (!tx_active_flag && !tx_done_flag) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      send       <= 1'b0;
      tx_data    <= '0;
      tx_timeout <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      send    <= (state_d == ST_REQ);
      if (pop) tx_data <= rdata;
      cnt_q   <= (state_q == ST_REQ && state_d == ST_REQ) ? cnt_q + CNT_W'(1) : '0;
      if (expire)     tx_timeout <= 1'b1;
      else if (flush) tx_timeout <= 1'b0;
    end
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: a Duplex TX stub, a queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_uart_tx_feeder;
  import uart_pkg::*;

  localparam int DEPTH       = 16;
  localparam int ADDR_W      = 4;
  localparam int ACK_TIMEOUT = 1024;

  localparam int M_IDLE   = 0;
  localparam int M_REQ    = 1;
  localparam int M_FRAME  = 2;
  localparam int M_SETTLE = 3;

  logic              clock          = 1'b1;
  logic              reset_n        = 1'b1;
  logic              flush          = 1'b0;
  logic              tx_active_flag = 1'b0;
  logic              tx_done_flag   = 1'b0;
  logic              send;
  logic [7:0]        tx_data;
  logic [ADDR_W:0]   fill_level;
  logic              empty, full, busy, tx_timeout;

  uart_tx_feeder_if ifc ();

  uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .wr             (ifc),
    .flush          (flush),
    .tx_active_flag (tx_active_flag),
    .tx_done_flag   (tx_done_flag),
    .send           (send),
    .tx_data        (tx_data),
    .fill_level     (fill_level),
    .empty          (empty),
    .full           (full),
    .busy           (busy),
    .tx_timeout     (tx_timeout)
  );

  always #10 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int max_fill = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, transmit progress as a phase.
  logic [7:0] m_q[$];
  int         m_phase = M_IDLE;
  int         m_wait  = 0;
  logic       m_to    = 1'b0;
  logic [7:0] m_txd   = 8'h00;
  logic       m_take, m_give, m_expire;

  initial forever begin
    @(posedge clock or negedge reset_n);
    if (!reset_n) begin
      m_q.delete();
      m_phase = M_IDLE;
      m_wait  = 0;
      m_to    = 1'b0;
      m_txd   = 8'h00;
    end else begin
      m_take   = ifc.wr_valid && (m_q.size() < DEPTH) && !flush;
      m_give   = (m_phase == M_IDLE) && (m_q.size() != 0) && !flush;
      m_expire = 1'b0;
      case (m_phase)
        M_IDLE:  if (m_give) begin m_phase = M_REQ; m_wait = 0; end
        M_REQ: begin
          if (tx_active_flag) m_phase = M_FRAME;
          else if (m_wait == ACK_TIMEOUT - 1) begin m_expire = 1'b1; m_phase = M_IDLE; end
          else m_wait++;
        end
        M_FRAME: if (tx_done_flag) m_phase = M_SETTLE;
        default: if (!tx_active_flag && !tx_done_flag) m_phase = M_IDLE;
      endcase
      if (flush) begin
        m_q.delete();
        m_to = 1'b0;
      end else begin
        if (m_give) m_txd = m_q.pop_front();
        if (m_take) m_q.push_back(ifc.wr_data);
      end
      if (m_expire) m_to = 1'b1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clock);
    if (reset_n) begin
      check("send",       send,          m_phase == M_REQ);
      check("tx_data",    tx_data,       m_txd);
      check("fill_level", fill_level,    m_q.size());
      check("empty",      empty,         m_q.size() == 0);
      check("full",       full,          m_q.size() == DEPTH);
      check("wr_ready",   ifc.wr_ready,  m_q.size() != DEPTH);
      check("busy",       busy,          m_phase != M_IDLE);
      check("tx_timeout", tx_timeout,    m_to);
      if (int'(fill_level) > max_fill) max_fill = int'(fill_level);
    end
  end

  // Duplex TX stub: active act_dly cycles after send, done after frame_len, held done_hold.
  bit         stub_en   = 1'b1;
  bit         stale_en  = 1'b0;
  int         act_dly   = 2;
  int         frame_len = 20;
  int         done_hold = 1;
  int         s_phase   = 0;
  int         s_cnt     = 0;
  logic [7:0] cap_q[$];

  initial forever begin
    @(negedge clock or negedge reset_n);
    if (!reset_n) begin
      s_phase = 0;
      tx_active_flag = 1'b0;
      tx_done_flag   = 1'b0;
    end else begin
      case (s_phase)
        0: if (stub_en && send) begin cap_q.push_back(tx_data); s_phase = 1; s_cnt = act_dly; end
        1: begin
          s_cnt--;
          tx_done_flag = stale_en ? 1'($urandom_range(0, 1)) : 1'b0;
          if (s_cnt <= 0) begin
            tx_active_flag = 1'b1; tx_done_flag = 1'b0; s_phase = 2; s_cnt = frame_len;
          end
        end
        2: begin
          s_cnt--;
          if (s_cnt <= 0) begin
            tx_active_flag = 1'b0; tx_done_flag = 1'b1; s_phase = 3; s_cnt = done_hold;
          end
        end
        default: begin
          s_cnt--;
          if (s_cnt <= 0) begin tx_done_flag = 1'b0; s_phase = 0; end
        end
      endcase
    end
  end

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    ifc.wr_valid = 1'b1;
    ifc.wr_data  = b;
    while (!ifc.wr_ready && n < 3000) begin @(negedge clock); n++; end
    if (n >= 3000) check("push_wait_bound", 0, 1);
    @(negedge clock);
    ifc.wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    while ((busy || !empty) && n < bound) begin @(negedge clock); n++; end
    check(name, n < bound, 1);
  endtask

  int n;
  int sends;

  initial begin
    ifc.wr_valid = 1'b0;
    ifc.wr_data  = 8'h00;

    // Reset then idle
    #1 reset_n = 1'b0;
    #4;
    check("rst_send", send, 0);
    check("rst_empty", empty, 1);
    check("rst_wr_ready", ifc.wr_ready, 1);
    check("rst_fill", fill_level, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", tx_timeout, 0);
    #6 reset_n = 1'b1;
    repeat (6) @(negedge clock);

    // Single byte
    ifc.wr_data = 8'hAA; ifc.wr_valid = 1'b1;
    @(negedge clock);
    ifc.wr_valid = 1'b0;
    check("single_empty_at_push", empty, 0);
    check("single_send_at_push", send, 0);
    check("single_fill_at_push", fill_level, 1);
    @(negedge clock);
    check("single_send_next", send, 1);
    check("single_tx_data", tx_data, 8'hAA);
    check("single_fill_popped", fill_level, 0);
    repeat (2) @(negedge clock);
    check("single_send_before_active", send, 1);
    @(negedge clock);
    check("single_send_after_active", send, 0);
    check("single_busy_active", busy, 1);
    wait_idle("single_idle_bound", 100);
    check("single_cap_n", cap_q.size(), 1);
    check("single_cap_0", cap_q.size() > 0 ? cap_q[0] : 8'hxx, 8'hAA);

    // Burst and full
    cap_q.delete();
    stub_en = 1'b0;
    fork
      begin
        for (int i = 0; i < 18; i++) push_byte(8'(i));
      end
      begin
        int k = 0;
        while (!full && k < 100) begin @(negedge clock); k++; end
        check("burst_full_bound", k < 100, 1);
        check("burst_full", full, 1);
        check("burst_wr_ready", ifc.wr_ready, 0);
        check("burst_fill", fill_level, 16);
        repeat (20) @(negedge clock);
        check("burst_fill_hold", fill_level, 16);
        stub_en = 1'b1;
      end
    join
    wait_idle("burst_drain_bound", 2000);
    check("burst_cap_n", cap_q.size(), 18);
    for (int i = 0; i < 18; i++)
      check($sformatf("burst_order_%0d", i), i < cap_q.size() ? cap_q[i] : 8'hxx, 8'(i));

    // Simultaneous push and pop at fill level 3
    cap_q.delete();
    stub_en = 1'b0;
    for (int i = 0; i < 4; i++) push_byte(8'(8'hB0 + i));
    check("simul_fill_pre", fill_level, 3);
    stub_en = 1'b1;
    n = 0;
    while (busy && n < 200) begin @(negedge clock); n++; end
    check("simul_idle_bound", n < 200, 1);
    push_byte(8'hB4);
    check("simul_fill_post", fill_level, 3);
    check("simul_busy", busy, 1);
    check("simul_tx_data", tx_data, 8'hB1);
    wait_idle("simul_drain_bound", 1000);
    check("simul_cap_n", cap_q.size(), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("simul_order_%0d", i), i < cap_q.size() ? cap_q[i] : 8'hxx, 8'(8'hB0 + i));

    // Timeout
    cap_q.delete();
    stub_en = 1'b0;
    push_byte(8'h55);
    push_byte(8'h66);
    check("to_send_start", send, 1);
    check("to_tx_data_55", tx_data, 8'h55);
    n = 0;
    while (!tx_timeout && n < 1100) begin @(negedge clock); n++; end
    check("to_cycles", n, ACK_TIMEOUT);
    check("to_send_dropped", send, 0);
    check("to_busy_idle", busy, 0);
    check("to_fill_waiting", fill_level, 1);
    @(negedge clock);
    check("to_next_send", send, 1);
    check("to_next_data", tx_data, 8'h66);
    check("to_sticky", tx_timeout, 1);
    push_byte(8'h77);
    check("to_fill_before_flush", fill_level, 1);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    check("to_flush_clear", tx_timeout, 0);
    check("to_flush_fill", fill_level, 0);
    check("to_flush_busy", busy, 1);
    stub_en = 1'b1;
    wait_idle("to_drain_bound", 200);
    check("to_cap_n", cap_q.size(), 1);
    check("to_cap_0", cap_q.size() > 0 ? cap_q[0] : 8'hxx, 8'h66);

    // Flush during ACTIVE with five queued
    cap_q.delete();
    frame_len = 30;
    for (int i = 0; i < 6; i++) push_byte(8'(8'hC0 + i));
    n = 0;
    while (!(busy && tx_active_flag) && n < 50) begin @(negedge clock); n++; end
    @(negedge clock);
    check("fl_fill_pre", fill_level, 5);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    check("fl_fill_post", fill_level, 0);
    check("fl_busy", busy, 1);
    wait_idle("fl_drain_bound", 200);
    sends = 0;
    repeat (30) begin @(negedge clock); if (send) sends++; end
    check("fl_no_more_send", sends, 0);
    check("fl_cap_0", cap_q.size() > 0 ? cap_q[0] : 8'hxx, 8'hC0);
    check("fl_cap_n", cap_q.size(), 1);
    frame_len = 20;

    // Reset during REQ
    stub_en = 1'b0;
    push_byte(8'h77);
    push_byte(8'h78);
    check("rr_send_req", send, 1);
    #2 reset_n = 1'b0;
    #1;
    check("rr_send_async", send, 0);
    check("rr_busy", busy, 0);
    check("rr_fill", fill_level, 0);
    @(negedge clock);
    reset_n = 1'b1;
    stub_en = 1'b1;
    repeat (3) @(negedge clock);

    // Randomized traffic
    stale_en = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (c % 64 == 0) begin
        act_dly   = $urandom_range(1, 4);
        frame_len = $urandom_range(1, 25);
        done_hold = $urandom_range(1, 3);
      end
      ifc.wr_valid = ($urandom_range(0, 2) != 0);
      ifc.wr_data  = 8'($urandom);
      flush        = ($urandom_range(0, 150) == 0);
      @(negedge clock);
    end
    ifc.wr_valid = 1'b0;
    flush        = 1'b0;
    wait_idle("rand_drain_bound", 5000);
    check("fill_never_above_depth", max_fill <= DEPTH, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
